// File: rtl/trap_pkg.sv
// Shared cause codes, CSR bit positions and FSM state type for the trap controller.
package trap_pkg;
  localparam int CAUSE_ILLEGAL   = 2;
  localparam int CAUSE_LD_FAULT  = 5;
  localparam int CAUSE_ST_FAULT  = 7;
  localparam int CAUSE_ECALL     = 11;
  localparam int MSTATUS_MIE_BIT = 3;

  typedef enum logic [1:0] {
    IDLE,
    COMMIT,
    REDIRECT
  } state_e;
endpackage

// File: rtl/trap_ctrl_if.sv
// MEM-stage / CSR-file bundle seen by the trap controller.
interface trap_ctrl_if #(
  parameter int XLEN = 32
);
  logic            mem_valid;
  logic [XLEN-1:0] mem_pc;
  logic [31:0]     mem_inst;
  logic [XLEN-1:0] mem_addr;
  logic            exc_illegal;
  logic            exc_ecall;
  logic            exc_ld_fault;
  logic            exc_st_fault;
  logic            mem_mret;
  logic            ext_irq;
  logic            csr_w;
  logic [XLEN-1:0] mstatus;
  logic [XLEN-1:0] mtvec;
  logic [XLEN-1:0] mepc_i;
  logic            is_trap;
  logic            is_mret;
  logic [XLEN-1:0] mepc;
  logic [XLEN-1:0] mcause;
  logic [XLEN-1:0] mtval;
  logic            flush;
  logic            redirect;
  logic [XLEN-1:0] redirect_pc;

  modport master (
    input  mem_valid, mem_pc, mem_inst, mem_addr,
    input  exc_illegal, exc_ecall, exc_ld_fault, exc_st_fault,
    input  mem_mret, ext_irq, csr_w, mstatus, mtvec, mepc_i,
    output is_trap, is_mret, mepc, mcause, mtval,
    output flush, redirect, redirect_pc
  );

  modport slave (
    output mem_valid, mem_pc, mem_inst, mem_addr,
    output exc_illegal, exc_ecall, exc_ld_fault, exc_st_fault,
    output mem_mret, ext_irq, csr_w, mstatus, mtvec, mepc_i,
    input  is_trap, is_mret, mepc, mcause, mtval,
    input  flush, redirect, redirect_pc
  );
endinterface

// File: rtl/trap_cause_enc.sv
// Priority encoder: irq > illegal > ecall > ld_fault > st_fault > mret.
module trap_cause_enc
  import trap_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int IRQ_CODE = 11
) (
  input  logic            irq_take_i,
  input  logic            illegal_i,
  input  logic            ecall_i,
  input  logic            ld_fault_i,
  input  logic            st_fault_i,
  input  logic            mret_i,
  input  logic [31:0]     inst_i,
  input  logic [XLEN-1:0] addr_i,
  output logic            hit_o,
  output logic            is_irq_o,
  output logic            is_mret_o,
  output logic [XLEN-1:0] cause_o,
  output logic [XLEN-1:0] tval_o
);
  always_comb begin
    hit_o     = 1'b1;
    is_irq_o  = 1'b0;
    is_mret_o = 1'b0;
    cause_o   = '0;
    tval_o    = '0;
    if (irq_take_i) begin
      is_irq_o = 1'b1;
      cause_o  = {1'b1, (XLEN-1)'(IRQ_CODE)};
    end else if (illegal_i) begin
      cause_o = XLEN'(CAUSE_ILLEGAL);
      tval_o  = XLEN'(inst_i);
    end else if (ecall_i) begin
      cause_o = XLEN'(CAUSE_ECALL);
    end else if (ld_fault_i) begin
      cause_o = XLEN'(CAUSE_LD_FAULT);
      tval_o  = addr_i;
    end else if (st_fault_i) begin
      cause_o = XLEN'(CAUSE_ST_FAULT);
      tval_o  = addr_i;
    end else if (mret_i) begin
      is_mret_o = 1'b1;
    end else begin
      hit_o = 1'b0;
    end
  end
endmodule

// File: rtl/trap_ctrl.sv
// Trap initiator: commits traps/mret to the CSR file, flushes and redirects fetch.
// Optional TRAP_VECTORED_EN: vectored mtvec mode for interrupts.
module trap_ctrl
  import trap_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int IRQ_CODE = 11
) (
  input  logic        clk,
  input  logic        rst_n,
  trap_ctrl_if.master bus
);
  state_e          state_q, state_d;
  logic            mret_q, mret_d;
  logic [XLEN-1:0] mepc_q, mepc_d;
  logic [XLEN-1:0] mcause_q, mcause_d;
  logic [XLEN-1:0] mtval_q, mtval_d;
  logic [XLEN-1:0] tgt_q, tgt_d;

  logic            irq_take;
  logic            hit;
  logic            is_irq;
  logic            is_mret;
  logic [XLEN-1:0] cause;
  logic [XLEN-1:0] tval;
  logic [XLEN-1:0] base;
  logic [XLEN-1:0] trap_tgt;

  assign irq_take = bus.ext_irq & bus.mstatus[MSTATUS_MIE_BIT];
  assign base     = {bus.mtvec[XLEN-1:2], 2'b00};

  trap_cause_enc #(
    .XLEN     (XLEN),
    .IRQ_CODE (IRQ_CODE)
  ) u_enc (
    .irq_take_i (irq_take),
    .illegal_i  (bus.exc_illegal),
    .ecall_i    (bus.exc_ecall),
    .ld_fault_i (bus.exc_ld_fault),
    .st_fault_i (bus.exc_st_fault),
    .mret_i     (bus.mem_mret),
    .inst_i     (bus.mem_inst),
    .addr_i     (bus.mem_addr),
    .hit_o      (hit),
    .is_irq_o   (is_irq),
    .is_mret_o  (is_mret),
    .cause_o    (cause),
    .tval_o     (tval)
  );

`ifdef TRAP_VECTORED_EN
  assign trap_tgt = (is_irq && bus.mtvec[1:0] == 2'b01)
                  ? base + XLEN'(4 * IRQ_CODE)
                  : base;
`else
  assign trap_tgt = base;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      mret_q   <= 1'b0;
      mepc_q   <= '0;
      mcause_q <= '0;
      mtval_q  <= '0;
      tgt_q    <= '0;
    end else begin
      state_q  <= state_d;
      mret_q   <= mret_d;
      mepc_q   <= mepc_d;
      mcause_q <= mcause_d;
      mtval_q  <= mtval_d;
      tgt_q    <= tgt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    mret_d   = mret_q;
    mepc_d   = mepc_q;
    mcause_d = mcause_q;
    mtval_d  = mtval_q;
    tgt_d    = tgt_q;
    unique case (state_q)
      IDLE: begin
        if (bus.mem_valid && hit) begin
          state_d = COMMIT;
          mret_d  = is_mret;
          // mret leaves mepc/mcause/mtval alone so the CSR rewrite is a no-op
          if (is_mret) begin
            tgt_d = bus.mepc_i;
          end else begin
            mepc_d   = bus.mem_pc;
            mcause_d = cause;
            mtval_d  = tval;
            tgt_d    = trap_tgt;
          end
        end
      end
      COMMIT: begin
        if (!bus.csr_w) state_d = REDIRECT;
      end
      REDIRECT: state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  assign bus.is_trap     = (state_q == COMMIT) & ~bus.csr_w & ~mret_q;
  assign bus.is_mret     = (state_q == COMMIT) & ~bus.csr_w & mret_q;
  assign bus.flush       = (state_q != IDLE);
  assign bus.redirect    = (state_q == REDIRECT);
  assign bus.redirect_pc = tgt_q;
  assign bus.mepc        = mepc_q;
  assign bus.mcause      = mcause_q;
  assign bus.mtval       = mtval_q;
endmodule

// File: tb/tb_trap_ctrl.sv
// Scoreboard bench for trap_ctrl; expectations queued at stimulus, popped at redirect.
module tb_trap_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  trap_ctrl_if #(.XLEN(32)) bus ();

  trap_ctrl #(
    .XLEN     (32),
    .IRQ_CODE (11)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic        mret;
    logic [31:0] mepc;
    logic [31:0] mcause;
    logic [31:0] mtval;
    logic [31:0] tgt;
  } exp_t;

  exp_t q[$];
  int   n_chk  = 0;
  int   n_pass = 0;
  int   pulses = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.is_trap || bus.is_mret) begin
        pulses++;
        if (q.size() == 0) begin
          chk("unexpected_pulse", 32'd1, 32'd0);
        end else begin
          chk("kind", {30'd0, bus.is_trap, bus.is_mret},
              {30'd0, !q[0].mret, q[0].mret});
          chk("mepc", bus.mepc, q[0].mepc);
          chk("mcause", bus.mcause, q[0].mcause);
          chk("mtval", bus.mtval, q[0].mtval);
        end
      end
      if (bus.redirect) begin
        if (q.size() == 0) begin
          chk("unexpected_redirect", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("redirect_pc", bus.redirect_pc, e.tgt);
          chk("redirect_flush", {31'd0, bus.flush}, 32'd1);
        end
      end
    end
  end

  task automatic push(input logic mr, input logic [31:0] pc, cause,
                      tval, tgt);
    exp_t e;
    e.mret = mr; e.mepc = pc; e.mcause = cause;
    e.mtval = tval; e.tgt = tgt;
    q.push_back(e);
  endtask

  task automatic clr();
    bus.mem_valid = 0; bus.exc_illegal = 0; bus.exc_ecall = 0;
    bus.exc_ld_fault = 0; bus.exc_st_fault = 0; bus.mem_mret = 0;
    bus.ext_irq = 0;
  endtask

  // Presents one MEM-stage slot for exactly one clock edge.
  task automatic fire(input logic [31:0] pc, inst, addr,
                      input logic il, ec, ld, st, mr, irq);
    bus.mem_pc = pc; bus.mem_inst = inst; bus.mem_addr = addr;
    bus.exc_illegal = il; bus.exc_ecall = ec; bus.exc_ld_fault = ld;
    bus.exc_st_fault = st; bus.mem_mret = mr; bus.ext_irq = irq;
    bus.mem_valid = 1;
    @(posedge clk); #1;
    clr();
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  localparam logic [31:0] IRQC = 32'h8000_000B;

  initial begin
    int p0;
    clr();
    bus.mem_pc = 0; bus.mem_inst = 0; bus.mem_addr = 0;
    bus.csr_w = 0; bus.mstatus = 0; bus.mtvec = 32'h200;
    bus.mepc_i = 0;
    idle(2);
    @(negedge clk);
    chk("rst_is_trap", {31'd0, bus.is_trap}, 32'd0);
    chk("rst_flush", {31'd0, bus.flush}, 32'd0);
    chk("rst_redirect", {31'd0, bus.redirect}, 32'd0);
    chk("rst_mcause", bus.mcause, 32'd0);
    chk("rst_redirect_pc", bus.redirect_pc, 32'd0);
    rst_n = 1;
    idle(2);

    // 1: illegal instruction, 1-cycle commit latency
    push(0, 32'h100, 32'd2, 32'hFFFF_FFFF, 32'h200);
    fire(32'h100, 32'hFFFF_FFFF, 0, 1, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("t1_latency", {31'd0, bus.is_trap}, 32'd1);
    chk("t1_flush", {31'd0, bus.flush}, 32'd1);
    idle(3);
    chk("t1_flush_clear", {31'd0, bus.flush}, 32'd0);

    // 2: ecall then mret to mepc_i; mcause keeps 11
    push(0, 32'h40, 32'd11, 32'd0, 32'h200);
    fire(32'h40, 0, 0, 0, 1, 0, 0, 0, 0);
    idle(3);
    bus.mepc_i = 32'h40;
    push(1, 32'h40, 32'd11, 32'd0, 32'h40);
    fire(32'h80, 0, 0, 0, 0, 0, 0, 1, 0);
    idle(3);

    // 3: irq masked, irq without mem_valid, then irq beats ld_fault
    p0 = pulses;
    bus.ext_irq = 1; bus.mem_valid = 1;
    idle(3);
    bus.mstatus = 32'h8; bus.mem_valid = 0;
    idle(3);
    bus.ext_irq = 0;
    chk("t3_no_trap", pulses, p0);
    push(0, 32'h88, IRQC, 32'd0, 32'h200);
    fire(32'h88, 0, 32'h1234, 0, 0, 1, 0, 0, 1);
    idle(3);
    bus.mstatus = 0;

    // 4: csr_w collision for two cycles
    p0 = pulses;
    push(0, 32'h90, 32'd7, 32'h55, 32'h200);
    fire(32'h90, 0, 32'h55, 0, 0, 0, 1, 0, 0);
    bus.csr_w = 1;
    @(negedge clk);
    chk("t4_suppressed", {31'd0, bus.is_trap}, 32'd0);
    idle(2);
    bus.csr_w = 0;
    @(negedge clk);
    chk("t4_delayed_pulse", {31'd0, bus.is_trap}, 32'd1);
    idle(3);
    chk("t4_once", pulses - p0, 32'd1);

    // 5: vectored mode only affects interrupts
    bus.mtvec = 32'h301; bus.mstatus = 32'h8;
`ifdef TRAP_VECTORED_EN
    push(0, 32'hA0, IRQC, 32'd0, 32'h32C);
`else
    push(0, 32'hA0, IRQC, 32'd0, 32'h300);
`endif
    fire(32'hA0, 0, 0, 0, 0, 0, 0, 0, 1);
    idle(3);
    bus.mstatus = 0;
    push(0, 32'hA4, 32'd2, 32'h0000_DEAD, 32'h300);
    fire(32'hA4, 32'h0000_DEAD, 0, 1, 0, 0, 0, 0, 0);
    idle(3);

    // 6: reset in COMMIT
    p0 = pulses;
    fire(32'hB0, 0, 0, 0, 1, 0, 0, 0, 0);
    rst_n = 0;
    #1;
    chk("t6_is_trap", {31'd0, bus.is_trap}, 32'd0);
    chk("t6_flush", {31'd0, bus.flush}, 32'd0);
    chk("t6_mcause", bus.mcause, 32'd0);
    idle(2);
    rst_n = 1;
    idle(5);
    chk("t6_no_pulse", pulses, p0);
    chk("t6_no_redirect", {31'd0, bus.redirect}, 32'd0);

    chk("queue_drained", q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
